// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Multicycle signed multiply/divide unit (MULT / DIV) for the MIPS-subset
//   datapath. A start strobe latches operands a (rs) and b (rt). The unit then
//   runs 32 shift-add or restoring-divide iterations on the operand magnitudes,
//   applies the signs in FIX, and loads HI/LO on the FIX->DONE edge.
//
//   Optional feature macro: MULT_DIV_DIVZERO_EN
//     Defined     : a div_zero port exists. A divide by zero finishes at once,
//                   with done and div_zero pulsing together one cycle after
//                   the start. HI/LO keep their values.
//     Not defined : a divide by zero runs the full sequence. FIX then forces
//                   LO = all ones and HI = dividend.
//
// Ports
//   clk          : clock
//   reset        : synchronous, active-high reset
//   start_mult   : start signed multiply (sampled only in IDLE, wins over div)
//   start_div    : start signed divide   (sampled only in IDLE)
//   a            : multiplicand / dividend, captured on the start edge
//   b            : multiplier / divisor,    captured on the start edge
//   busy         : operation in progress (low in the done cycle)
//   done         : one-cycle pulse, hi/lo valid from this cycle on
//   hi, lo       : HI / LO result registers
//   div_zero     : one-cycle divide-by-zero pulse (MULT_DIV_DIVZERO_EN only)
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULT_DIV_DIVZERO_EN
  ,
  output logic             div_zero
`endif
);

  // Counter value on which the last iteration runs.
  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Magnitude of a two's-complement value. The most negative value maps onto
  // itself, and that bit pattern read as unsigned is exactly 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    magnitude = x[WIDTH-1] ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  // Conditional two's-complement negation, WIDTH bits.
  function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] x);
    neg_if = neg ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  // Conditional two's-complement negation, 2*WIDTH bits.
  function automatic logic [2*WIDTH-1:0] neg_if2(input logic neg, input logic [2*WIDTH-1:0] x);
    neg_if2 = neg ? (~x + {{(2*WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  state_t               state_r, state_s;
  logic [5:0]           cnt_r;
  logic                 is_div_r;
  logic                 sign_a_r;
  logic                 sign_b_r;
  logic                 dz_r;          // divisor was zero at start
  logic [WIDTH-1:0]     a_r;           // raw dividend, forced into HI on divide by zero
  logic [2*WIDTH-1:0]   prod_r;        // unsigned working product
  logic [2*WIDTH-1:0]   mcand_r;       // |a|, shifted left every iteration
  logic [WIDTH-1:0]     mplier_r;      // |b|, shifted right every iteration
  logic [WIDTH-1:0]     rem_r;         // partial remainder (always < divisor)
  logic [WIDTH-1:0]     quo_r;         // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]     divisor_r;     // |b|
  logic [WIDTH-1:0]     hi_r, lo_r;
  logic                 busy_r, done_r, div_zero_r;

  logic                 start_any_s;
  logic                 dz_start_s;
  logic [WIDTH:0]       div_shift_s;   // 33-bit working remainder for one step
  logic [WIDTH:0]       div_trial_s;
  logic [WIDTH-1:0]     rem_next_s, quo_next_s;
  logic [2*WIDTH-1:0]   prod_signed_s;
  logic [WIDTH-1:0]     hi_fix_s, lo_fix_s;

  assign start_any_s = start_mult | start_div;

  // Detect the divide-by-zero short path taken straight out of IDLE.
  always_comb begin
    dz_start_s = 1'b0;
`ifdef MULT_DIV_DIVZERO_EN
    if ((state_r == S_IDLE) && !start_mult && start_div && (b == {WIDTH{1'b0}})) begin
      dz_start_s = 1'b1;
    end else begin
      dz_start_s = 1'b0;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_mult) begin
          state_s = S_MULT;
        end else if (dz_start_s) begin
          state_s = S_DONE;
        end else if (start_div) begin
          state_s = S_DIV;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_MULT: begin
        if (cnt_r == LAST_ITER) begin
          state_s = S_FIX;
        end else begin
          state_s = S_MULT;
        end
      end
      S_DIV: begin
        if (cnt_r == LAST_ITER) begin
          state_s = S_FIX;
        end else begin
          state_s = S_DIV;
        end
      end
      S_FIX:   state_s = S_DONE;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // One restoring-division step: bring in the next dividend bit and try to
  // subtract the divisor. A borrow out of bit WIDTH means "restore".
  always_comb begin
    div_shift_s = {rem_r, quo_r[WIDTH-1]};
    div_trial_s = div_shift_s - {1'b0, divisor_r};
    if (div_trial_s[WIDTH]) begin
      rem_next_s = div_shift_s[WIDTH-1:0];
      quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
    end else begin
      rem_next_s = div_trial_s[WIDTH-1:0];
      quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
    end
  end

  // Sign fix-up and selection of the values HI/LO load at FIX->DONE.
  always_comb begin
    prod_signed_s = neg_if2(sign_a_r ^ sign_b_r, prod_r);
    if (is_div_r) begin
      if (dz_r) begin
        hi_fix_s = a_r;
        lo_fix_s = {WIDTH{1'b1}};
      end else begin
        // Quotient truncates toward zero; remainder follows the dividend.
        hi_fix_s = neg_if(sign_a_r, rem_r);
        lo_fix_s = neg_if(sign_a_r ^ sign_b_r, quo_r);
      end
    end else begin
      hi_fix_s = prod_signed_s[2*WIDTH-1:WIDTH];
      lo_fix_s = prod_signed_s[WIDTH-1:0];
    end
  end

  // Operand capture, iteration datapath and HI/LO load.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= 6'd0;
      is_div_r  <= 1'b0;
      sign_a_r  <= 1'b0;
      sign_b_r  <= 1'b0;
      dz_r      <= 1'b0;
      a_r       <= {WIDTH{1'b0}};
      prod_r    <= {(2*WIDTH){1'b0}};
      mcand_r   <= {(2*WIDTH){1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      quo_r     <= {WIDTH{1'b0}};
      divisor_r <= {WIDTH{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_any_s && !dz_start_s) begin
            cnt_r     <= 6'd0;
            is_div_r  <= ~start_mult;
            sign_a_r  <= a[WIDTH-1];
            sign_b_r  <= b[WIDTH-1];
            dz_r      <= (b == {WIDTH{1'b0}});
            a_r       <= a;
            prod_r    <= {(2*WIDTH){1'b0}};
            mcand_r   <= {{WIDTH{1'b0}}, magnitude(a)};
            mplier_r  <= magnitude(b);
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= magnitude(a);
            divisor_r <= magnitude(b);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        S_MULT: begin
          if (mplier_r[0]) begin
            prod_r <= prod_r + mcand_r;
          end else begin
            prod_r <= prod_r;
          end
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          cnt_r    <= cnt_r + 6'd1;
        end
        S_DIV: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r + 6'd1;
        end
        S_FIX: begin
          hi_r <= hi_fix_s;
          lo_r <= lo_fix_s;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Registered status outputs, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      busy_r     <= (state_s == S_MULT) || (state_s == S_DIV) || (state_s == S_FIX);
      done_r     <= (state_s == S_DONE);
      div_zero_r <= dz_start_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;
`ifdef MULT_DIV_DIVZERO_EN
  assign div_zero = div_zero_r;
`else
  // Without the port the pulse has no consumer; keep it tied into the logic.
  logic unused_s;
  assign unused_s = div_zero_r;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//   Scoreboard bench for mult_div_unit. The stimulus tasks push the expected
//   HI/LO/div_zero and done timing into a queue. An independent monitor pops
//   an entry on every done pulse and compares.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MULT_DIV_DIVZERO_EN
  logic        div_zero;
`endif

  mult_div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
`ifdef MULT_DIV_DIVZERO_EN
    ,
    .div_zero   (div_zero)
`endif
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          e0;     // cycle count at the start edge
    int          lat;    // edges from start edge to the edge that raises done
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] cur_hi = 32'h0;   // bench model of HI/LO
  logic [31:0] cur_lo = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with empty scoreboard (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("hi", {32'h0, hi}, {32'h0, e.hi});
        chk("lo", {32'h0, lo}, {32'h0, e.lo});
        chk("done_latency", 64'(cyc - e.e0), 64'(e.lat));
        chk("busy_in_done", {63'h0, busy}, 64'h0);
`ifdef MULT_DIV_DIVZERO_EN
        chk("div_zero", {63'h0, div_zero}, {63'h0, e.dz});
`endif
      end
    end
  end

  // Issue one operation and wait (bounded) until the monitor has consumed it.
  task automatic op(input logic sm, input logic sd, input logic [31:0] va, input logic [31:0] vb,
                    input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                    input int elat, input logic ebusy);
    exp_t e;
    int   n;
    @(negedge clk);
    start_mult = sm;
    start_div  = sd;
    a = va;
    b = vb;
    e.hi = ehi; e.lo = elo; e.dz = edz; e.e0 = cyc + 1; e.lat = elat;
    sb_q.push_back(e);
    cur_hi = ehi;
    cur_lo = elo;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    a = 32'hDEAD_BEEF;     // operands must already be latched
    b = 32'h1234_5678;
    chk("busy_after_start", {63'h0, busy}, {63'h0, ebusy});
    #1;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles, pending=%0d", n, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a = 32'h0;
    b = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_hi",   {32'h0, hi}, 64'h0);
    chk("reset_lo",   {32'h0, lo}, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_done", {63'h0, done}, 64'h0);

    // Multiplies
    op(1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 1'b1);
    op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33, 1'b1);
    op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33, 1'b1);

    // Divides
    op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 1'b1);
    op(1'b0, 1'b1, 32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 33, 1'b1);
    op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 33, 1'b1);
    op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33, 1'b1);

    // Divide by zero
`ifdef MULT_DIV_DIVZERO_EN
    op(1'b0, 1'b1, 32'd5, 32'd0, cur_hi, cur_lo, 1'b1, 0, 1'b0);
`else
    op(1'b0, 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0, 33, 1'b1);
`endif

    // Both strobes: multiply wins, a single done, nothing queued afterwards
    op(1'b1, 1'b1, 32'd6, 32'd3, 32'd0, 32'd18, 1'b0, 33, 1'b1);
    repeat (40) @(negedge clk);

    // Abort by reset mid-operation, with an ignored start_div while busy
    @(negedge clk);
    start_mult = 1'b1; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (8) @(negedge clk);
    start_div = 1'b1; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start_div = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_hi",   {32'h0, hi}, 64'h0);
    chk("abort_lo",   {32'h0, lo}, 64'h0);
    chk("abort_busy", {63'h0, busy}, 64'h0);
    repeat (45) @(negedge clk);
    op(1'b1, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33, 1'b1);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
